queue_param_fifo: RTL and testbench

- Parametrised synchronous FIFO: next generation of the addressed 1-read/1-write register queue.
- Internal head/tail pointers, occupancy count, full/empty/almost-full flags, and a push/pop handshake replace externally driven addresses.
- Used as the generic buffering primitive between pipeline stages, e.g. issue-to-exec and LSU return queues.
- Read data is first-word fall-through: the head entry is always visible.

---
 rtl/queue_param_fifo_pkg.sv | 19 +
 rtl/queue_fifo_ptr_ctrl.sv | 85 ++++++++
 rtl/queue_param_fifo.sv | 65 ++++++
 tb/tb_queue_param_fifo.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/queue_param_fifo_pkg.sv
// Shared definitions for the parametrised queue family: count width,
// error-bit indices and the wrapping pointer increment.
package queue_param_fifo_pkg;

  localparam int QF_ERR_OVF = 0;
  localparam int QF_ERR_UDF = 1;

  // Occupancy needs one more bit than a pointer so that "full" is representable.
  function automatic int qf_cnt_w(input int bits);
    return bits + 1;
  endfunction

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic int unsigned qf_ptr_inc(input int unsigned ptr,
                                             input int unsigned size);
    return (ptr == size - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/queue_fifo_ptr_ctrl.sv
// Head/tail/count bookkeeping, request acceptance and status flags for the FIFO.
// Optional sticky error flags are built when QUEUE_PARAM_FIFO_ERR_EN is defined.
module queue_fifo_ptr_ctrl
  import queue_param_fifo_pkg::*;
#(
  parameter int BITS     = 2,
  parameter int SIZE     = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_push,
  input  logic                      in_pop,
  output logic [BITS-1:0]           out_head,
  output logic [BITS-1:0]           out_tail,
  output logic                      out_wr_en,
  output logic                      out_empty,
  output logic                      out_full,
  output logic                      out_almost_full,
  output logic [qf_cnt_w(BITS)-1:0] out_count
`ifdef QUEUE_PARAM_FIFO_ERR_EN
  ,
  output logic [1:0]                out_err
`endif
);

  localparam int CW = qf_cnt_w(BITS);

  logic [BITS-1:0] r_head;
  logic [BITS-1:0] r_tail;
  logic [CW-1:0]   r_count;
  logic [BITS-1:0] w_head_nxt;
  logic [BITS-1:0] w_tail_nxt;
  logic            w_push_acc;
  logic            w_pop_acc;

  // Flags come from the registered count only.
  assign out_empty       = (r_count == '0);
  assign out_full        = (r_count == CW'(SIZE));
  assign out_almost_full = (r_count >= CW'(AF_LEVEL));

  // A pop frees the slot this cycle, so a full FIFO may still accept a push.
  assign w_push_acc = in_push & (~out_full | in_pop);
  assign w_pop_acc  = in_pop & ~out_empty;

  assign w_head_nxt = BITS'(qf_ptr_inc(32'(r_head), SIZE));
  assign w_tail_nxt = BITS'(qf_ptr_inc(32'(r_tail), SIZE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop_acc)  r_head <= w_head_nxt;
      if (w_push_acc) r_tail <= w_tail_nxt;
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_head  = r_head;
  assign out_tail  = r_tail;
  assign out_wr_en = w_push_acc;
  assign out_count = r_count;

`ifdef QUEUE_PARAM_FIFO_ERR_EN
  logic [1:0] r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      if (in_push & ~w_push_acc) r_err[QF_ERR_OVF] <= 1'b1;
      if (in_pop & out_empty)    r_err[QF_ERR_UDF] <= 1'b1;
    end
  end

  assign out_err = r_err;
`endif

endmodule

// File: rtl/queue_param_fifo.sv
// Parametrised first-word-fall-through FIFO: storage array plus pointer control.
// Define QUEUE_PARAM_FIFO_ERR_EN to add the sticky out_err overflow/underflow port.
module queue_param_fifo
  import queue_param_fifo_pkg::*;
#(
  parameter int BITS     = 2,
  parameter int SIZE     = 4,
  parameter int WIDTH    = 32,
  parameter int AF_LEVEL = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_push,
  input  logic [WIDTH-1:0]          in_wr_data,
  input  logic                      in_pop,
  output logic [WIDTH-1:0]          out_rd_data,
  output logic                      out_empty,
  output logic                      out_full,
  output logic                      out_almost_full,
  output logic [qf_cnt_w(BITS)-1:0] out_count
`ifdef QUEUE_PARAM_FIFO_ERR_EN
  ,
  output logic [1:0]                out_err
`endif
);

  logic [WIDTH-1:0] r_mem [SIZE];
  logic [BITS-1:0]  w_head;
  logic [BITS-1:0]  w_tail;
  logic             w_wr_en;

  queue_fifo_ptr_ctrl #(
    .BITS     (BITS),
    .SIZE     (SIZE),
    .AF_LEVEL (AF_LEVEL)
  ) u_ptr_ctrl (
    .clk             (clk),
    .rst             (rst),
    .in_push         (in_push),
    .in_pop          (in_pop),
    .out_head        (w_head),
    .out_tail        (w_tail),
    .out_wr_en       (w_wr_en),
    .out_empty       (out_empty),
    .out_full        (out_full),
    .out_almost_full (out_almost_full),
    .out_count       (out_count)
`ifdef QUEUE_PARAM_FIFO_ERR_EN
    ,
    .out_err         (out_err)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_tail] <= in_wr_data;
    end
  end

  // Head entry straight from storage; writes land a cycle later, so no bypass.
  assign out_rd_data = r_mem[w_head];

endmodule

// File: tb/tb_queue_param_fifo.sv
// Directed plus randomized bench for queue_param_fifo: one SIZE=4 and one SIZE=3
// instance share stimulus and are checked against queue-based reference models.
module tb_queue_param_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] wdata = '0;

  logic [31:0] rd_a, rd_b;
  logic        em_a, fu_a, af_a, em_b, fu_b, af_b;
  logic [2:0]  cnt_a, cnt_b;
`ifdef QUEUE_PARAM_FIFO_ERR_EN
  logic [1:0]  err_a, err_b;
  logic [1:0]  exp_err_a = '0, exp_err_b = '0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  queue_param_fifo #(.BITS(2), .SIZE(4), .WIDTH(32), .AF_LEVEL(3)) dut_a (
    .clk(clk), .rst(rst), .in_push(push), .in_wr_data(wdata), .in_pop(pop),
    .out_rd_data(rd_a), .out_empty(em_a), .out_full(fu_a),
    .out_almost_full(af_a), .out_count(cnt_a)
`ifdef QUEUE_PARAM_FIFO_ERR_EN
    , .out_err(err_a)
`endif
  );

  queue_param_fifo #(.BITS(2), .SIZE(3), .WIDTH(32), .AF_LEVEL(2)) dut_b (
    .clk(clk), .rst(rst), .in_push(push), .in_wr_data(wdata), .in_pop(pop),
    .out_rd_data(rd_b), .out_empty(em_b), .out_full(fu_b),
    .out_almost_full(af_b), .out_count(cnt_b)
`ifdef QUEUE_PARAM_FIFO_ERR_EN
    , .out_err(err_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_count", 32'(cnt_a), 32'(qa.size()));
    chk("a_empty", 32'(em_a), 32'(qa.size() == 0));
    chk("a_full",  32'(fu_a), 32'(qa.size() == 4));
    chk("a_afull", 32'(af_a), 32'(qa.size() >= 3));
    if (qa.size() > 0) chk("a_rdata", rd_a, qa[0]);
    chk("b_count", 32'(cnt_b), 32'(qb.size()));
    chk("b_empty", 32'(em_b), 32'(qb.size() == 0));
    chk("b_full",  32'(fu_b), 32'(qb.size() == 3));
    chk("b_afull", 32'(af_b), 32'(qb.size() >= 2));
    if (qb.size() > 0) chk("b_rdata", rd_b, qb[0]);
`ifdef QUEUE_PARAM_FIFO_ERR_EN
    chk("a_err", 32'(err_a), 32'(exp_err_a));
    chk("b_err", 32'(err_b), 32'(exp_err_b));
`endif
  endtask

  // One clock of stimulus; the models apply the acceptance rules on pre-edge occupancy.
  task automatic step(input bit p, input bit q, input logic [31:0] d);
    int  na, nb;
    bit  pa, oa, pb, ob;
    push = p; pop = q; wdata = d;
    @(posedge clk);
    na = qa.size(); nb = qb.size();
    pa = p && (na < 4 || q); oa = q && na > 0;
    pb = p && (nb < 3 || q); ob = q && nb > 0;
    if (oa) void'(qa.pop_front());
    if (pa) qa.push_back(d);
    if (ob) void'(qb.pop_front());
    if (pb) qb.push_back(d);
`ifdef QUEUE_PARAM_FIFO_ERR_EN
    if (p && !pa) exp_err_a[0] = 1'b1;
    if (q && na == 0) exp_err_a[1] = 1'b1;
    if (p && !pb) exp_err_b[0] = 1'b1;
    if (q && nb == 0) exp_err_b[1] = 1'b1;
`endif
    #1;
    push = 1'b0; pop = 1'b0;
    check_all();
  endtask

  task automatic clear_models();
    qa.delete(); qb.delete();
`ifdef QUEUE_PARAM_FIFO_ERR_EN
    exp_err_a = '0; exp_err_b = '0;
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    chk("a_rdata_reset", rd_a, 32'h0);
    chk("b_rdata_reset", rd_b, 32'h0);

    // Fill A to full, with almost-full and full flags walking up.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'hA0 + 32'(i));
    chk("a_full_at4", 32'(fu_a), 32'h1);
    step(1'b1, 1'b0, 32'hA4);
    chk("a_count_drop", 32'(cnt_a), 32'd4);

    // Drain, then an ignored pop on empty.
    for (int i = 0; i < 4; i++) begin
      if (i < 4) chk("a_drain_order", rd_a, 32'hA0 + 32'(i));
      step(1'b0, 1'b1, 32'h0);
    end
    chk("a_empty_drained", 32'(em_a), 32'h1);
    step(1'b0, 1'b1, 32'h0);

    // Push+pop while full keeps count at SIZE and appends behind the survivors.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'hA0 + 32'(i));
    step(1'b1, 1'b1, 32'hB0);
    chk("a_count_full_pp", 32'(cnt_a), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h0);

    // Push+pop while empty: only the push lands.
    step(1'b1, 1'b1, 32'hC5);
    chk("a_rdata_c5", rd_a, 32'hC5);

    // Steady single-entry traffic walks both pointers around the ring.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'h10 + 32'(i));
    chk("b_count_steady", 32'(cnt_b), 32'd1);
    chk("b_rdata_last", rd_b, 32'h19);

    // Asynchronous reset lands between clock edges.
    step(1'b1, 1'b0, 32'h55);
    @(negedge clk);
    rst = 1'b1;
    #1;
    clear_models();
    chk("a_async_count", 32'(cnt_a), 32'd0);
    chk("a_async_empty", 32'(em_a), 32'h1);
    chk("a_async_rdata", rd_a, 32'h0);
    chk("b_async_rdata", rd_b, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();

    // Randomized traffic, biased so both full and empty boundaries occur.
    for (int i = 0; i < 400; i++) begin
      int mode;
      mode = (i / 50) % 2;
      step(($urandom_range(0, 9) < (mode ? 3 : 7)) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < (mode ? 7 : 3)) ? 1'b1 : 1'b0,
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
